// File: rtl/fetch_pc_npc_stage.sv
// ---------------------------------------------------------------------------
// fetch_pc_npc_stage
//   SPARC fetch stage with delayed-branch PC/nPC semantics. Holds the PC/nPC
//   pair, addresses instruction memory with PC, and latches the fetched word
//   into the IF/ID pipeline register. Hazard stalls freeze everything, and
//   branch redirects load nPC so the delay slot (old nPC) is still fetched.
//   Annulled delay-slot instructions are replaced by NOP_INSTR.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   LE            load enable; 0 = stall (hold PC, nPC, IF/ID)
//   nPC_Sel[1:0]  00/11 nPC+4, 01 TA, 10 Jumpl_Target
//   TA[31:0]      branch/call target from ID
//   Jumpl_Target  jumpl target from ALU
//   Annul         squash the instruction currently being fetched
//   Imem_Data     instruction word at Imem_Addr (combinational ROM)
//   Imem_Addr     = PC
//   PC, nPC       current / next fetch address
//   IF_ID_Instr   instruction presented to decode
//   IF_ID_PC      PC of IF_ID_Instr
//   IF_ID_Valid   1 = real fetched instruction, 0 = injected NOP
// ---------------------------------------------------------------------------
module fetch_pc_npc_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LE,
    input  logic [1:0]  nPC_Sel,
    input  logic [31:0] TA,
    input  logic [31:0] Jumpl_Target,
    input  logic        Annul,
    input  logic [31:0] Imem_Data,
    output logic [31:0] Imem_Addr,
    output logic [31:0] PC,
    output logic [31:0] nPC,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PC,
    output logic        IF_ID_Valid
);

    logic [31:0] pc_q;
    logic [31:0] npc_q;
    logic [31:0] npc_d;
    logic [31:0] instr_q;
    logic [31:0] ifid_pc_q;
    logic        valid_q;
    logic        annul_pend_q;
    logic        squash;

    // Targets are word-aligned on load so PC/nPC never carry low bits.
    always_comb begin
        npc_d = npc_q + 32'd4;
        case (nPC_Sel)
            2'b01:   npc_d = {TA[31:2], 2'b00};
            2'b10:   npc_d = {Jumpl_Target[31:2], 2'b00};
            default: npc_d = npc_q + 32'd4;
        endcase
    end

    // An annul seen during a stall is remembered so it still squashes the
    // word that is finally latched on the next advance.
    assign squash = Annul | annul_pend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            npc_q        <= RESET_PC + 32'd4;
            instr_q      <= NOP_INSTR;
            ifid_pc_q    <= 32'h0000_0000;
            valid_q      <= 1'b0;
            annul_pend_q <= 1'b0;
        end else if (LE) begin
            ifid_pc_q    <= pc_q;
            instr_q      <= squash ? NOP_INSTR : Imem_Data;
            valid_q      <= ~squash;
            pc_q         <= npc_q;
            npc_q        <= npc_d;
            annul_pend_q <= 1'b0;
        end else if (Annul) begin
            annul_pend_q <= 1'b1;
        end
    end

    assign Imem_Addr   = pc_q;
    assign PC          = pc_q;
    assign nPC         = npc_q;
    assign IF_ID_Instr = instr_q;
    assign IF_ID_PC    = ifid_pc_q;
    assign IF_ID_Valid = valid_q;

endmodule
